// File: rtl/boid_fb_writer_if.sv
// boid_fb_writer_if
//   Bundles the BPU position-update handshake and the framebuffer BRAM write
//   port used by boid_fb_writer.
//   Signals:
//     in_valid / in_ready   update handshake (accept when both high)
//     in_id, in_x, in_y     boid index and top-left sprite position
//     fb_we, fb_addr,       framebuffer write port (20-bit pixel address,
//     fb_wdata              9-bit palette index)
//     done                  one-cycle pulse when an update has finished
//   Modports:
//     master  upstream/testbench side (drives the update, observes the rest)
//     slave   boid_fb_writer side
interface boid_fb_writer_if #(
  parameter int ID_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [ID_W-1:0] in_id;
  logic [9:0]      in_x;
  logic [8:0]      in_y;
  logic            fb_we;
  logic [19:0]     fb_addr;
  logic [8:0]      fb_wdata;
  logic            done;

  modport master (
    output in_valid, in_id, in_x, in_y,
    input  in_ready, fb_we, fb_addr, fb_wdata, done
  );

  modport slave (
    input  in_valid, in_id, in_x, in_y,
    output in_ready, fb_we, fb_addr, fb_wdata, done
  );
endinterface

// File: rtl/boid_fb_writer.sv
// boid_fb_writer
//   Renders boid position updates from the BPU into the VGA framebuffer.
//   Each update erases the boid's previous SIZE x SIZE square in BG_COLOR and
//   then draws the new square in BOID_COLOR, one pixel per clock in raster
//   order (dx fastest). Pixels outside 640x480 are skipped but still take
//   their cycle, so update latency is fixed.
//   Ports:
//     clock   system clock
//     reset   synchronous, active-high
//     bus     boid_fb_writer_if.slave (update handshake + framebuffer port)
//   Configuration macro:
//     BOID_TRAIL_EN  when defined the erase pass is never run, leaving trails;
//                    positions and valid bits are still tracked.
module boid_fb_writer #(
  parameter int         NUM_BOIDS  = 8,
  parameter int         SIZE       = 2,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic           clock,
  input  logic           reset,
  boid_fb_writer_if.slave bus
);
  localparam int ID_W = $clog2(NUM_BOIDS);
  localparam logic [1:0]    LAST = 2'(SIZE - 1);
  localparam logic [ID_W:0] NB   = (ID_W + 1)'(NUM_BOIDS);

`ifdef BOID_TRAIL_EN
  localparam bit ERASE_EN = 1'b0;
`else
  localparam bit ERASE_EN = 1'b1;
`endif

  // FLUSH covers the cycle in which the final draw write is on the bus;
  // done is registered out of it so it lands on the first IDLE cycle.
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FLUSH} state_t;

  state_t state, state_d;

  logic [1:0]      dx, dy;
  logic [ID_W-1:0] cur_id;
  logic [9:0]      new_x, old_x;
  logic [8:0]      new_y, old_y;
  logic [9:0]      pos_x [NUM_BOIDS];
  logic [8:0]      pos_y [NUM_BOIDS];
  logic [NUM_BOIDS-1:0] valid;

  logic        accept, id_ok, last_pix;
  logic [9:0]  base_x;
  logic [8:0]  base_y;
  logic [10:0] px;
  logic [9:0]  py;
  logic        clip;
  logic [19:0] addr;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign id_ok        = {1'b0, bus.in_id} < NB;
  assign last_pix     = (dx == LAST) && (dy == LAST);

  // Current pixel coordinate, clip test and x + 640*y without a multiplier.
  always_comb begin
    base_x = (state == ERASE) ? old_x : new_x;
    base_y = (state == ERASE) ? old_y : new_y;
    px     = {1'b0, base_x} + {9'b0, dx};
    py     = {1'b0, base_y} + {8'b0, dy};
    clip   = (px >= 11'd640) || (py >= 10'd480);
    addr   = {9'b0, px} + {1'b0, py, 9'b0} + {3'b0, py, 7'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (accept && id_ok)
               state_d = (ERASE_EN && valid[bus.in_id]) ? ERASE : DRAW;
      ERASE: if (last_pix) state_d = DRAW;
      DRAW:  if (last_pix) state_d = FLUSH;
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid        <= '0;
      dx           <= '0;
      dy           <= '0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_wdata <= '0;
      bus.done     <= 1'b0;
    end else begin
      // An out-of-range id is accepted and dropped: done follows immediately.
      bus.done  <= (state == FLUSH) || (accept && !id_ok);
      bus.fb_we <= 1'b0;

      if (state == ERASE || state == DRAW) begin
        bus.fb_we    <= !clip;
        bus.fb_addr  <= addr;
        bus.fb_wdata <= {1'b0, (state == ERASE) ? BG_COLOR : BOID_COLOR};
        if (dx == LAST) begin
          dx <= '0;
          dy <= (dy == LAST) ? 2'd0 : dy + 2'd1;
        end else begin
          dx <= dx + 2'd1;
        end
      end

      if (accept && id_ok) begin
        cur_id <= bus.in_id;
        new_x  <= bus.in_x;
        new_y  <= bus.in_y;
        old_x  <= pos_x[bus.in_id];
        old_y  <= pos_y[bus.in_id];
        dx     <= '0;
        dy     <= '0;
      end

      if (state == DRAW && last_pix) begin
        pos_x[cur_id] <= new_x;
        pos_y[cur_id] <= new_y;
        valid[cur_id] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_boid_fb_writer.sv
// tb_boid_fb_writer
//   Directed, table-driven bench for boid_fb_writer (NUM_BOIDS=8, SIZE=2).
//   Each table record is one update plus its expected write list and done
//   cycle; a few hand-written sequences cover back-to-back accepts and reset
//   in the middle of a draw. Expectations follow BOID_TRAIL_EN if defined.
module tb_boid_fb_writer;
`ifdef BOID_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  boid_fb_writer_if #(.ID_W(3)) bus();

  boid_fb_writer #(
    .NUM_BOIDS (8),
    .SIZE      (2),
    .BOID_COLOR(8'hFF),
    .BG_COLOR  (8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  id;
    logic [9:0]  x;
    logic [8:0]  y;
    int unsigned first;
    int unsigned nw;
    int unsigned done_c;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [19:0] addr;
    logic [8:0]  data;
  } wr_t;

  vec_t vecs[$];
  wr_t  wrs[$];
  vec_t cur;
  int unsigned slot;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic vbegin(input logic [2:0] id, input logic [9:0] x, input logic [8:0] y);
    cur.id = id; cur.x = x; cur.y = y;
    cur.first = wrs.size(); cur.nw = 0; cur.done_c = 0;
    slot = 0;
  endtask

  // One pixel slot: er = erase pass, wr = pixel lies on screen.
  task automatic pix(input bit er, input bit wr, input logic [19:0] addr);
    wr_t w;
    if (er && TRAIL) return;
    slot++;
    if (wr) begin
      w.cyc  = slot + 1;
      w.addr = addr;
      w.data = er ? 9'h000 : 9'h0FF;
      wrs.push_back(w);
      cur.nw++;
    end
  endtask

  task automatic vend();
    cur.done_c = slot + 2;
    vecs.push_back(cur);
  endtask

  task automatic run_vec(input int unsigned i);
    vec_t v;
    wr_t  e;
    int unsigned seen, done_at, rdy_at;
    v = vecs[i]; seen = 0; done_at = 0; rdy_at = 0;
    @(negedge clock);
    chk($sformatf("v%0d_ready_before", i), bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_id = v.id; bus.in_x = v.x; bus.in_y = v.y;
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int unsigned c = 1; c <= 24 && done_at == 0; c++) begin
      if (bus.fb_we) begin
        if (seen < v.nw) begin
          e = wrs[v.first + seen];
          chk($sformatf("v%0d_w%0d_cycle", i, seen), c, e.cyc);
          chk($sformatf("v%0d_w%0d_addr", i, seen), bus.fb_addr, e.addr);
          chk($sformatf("v%0d_w%0d_data", i, seen), bus.fb_wdata, e.data);
        end
        seen++;
      end
      if (bus.in_ready && rdy_at == 0) rdy_at = c;
      if (bus.done) done_at = c;
      @(negedge clock);
    end
    chk($sformatf("v%0d_nwrites", i), seen, v.nw);
    chk($sformatf("v%0d_done_cycle", i), done_at, v.done_c);
    chk($sformatf("v%0d_ready_cycle", i), rdy_at, v.done_c);
  endtask

  int unsigned rdy, d;

  initial begin
    bus.in_valid = 1'b0; bus.in_id = '0; bus.in_x = '0; bus.in_y = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_fb_wdata", bus.fb_wdata, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // 0: first draw of id0
    vbegin(0, 100, 100);
    pix(0, 1, 64100); pix(0, 1, 64101); pix(0, 1, 64740); pix(0, 1, 64741);
    vend();
    // 1: move id0 right by one
    vbegin(0, 101, 100);
    pix(1, 1, 64100); pix(1, 1, 64101); pix(1, 1, 64740); pix(1, 1, 64741);
    pix(0, 1, 64101); pix(0, 1, 64102); pix(0, 1, 64741); pix(0, 1, 64742);
    vend();
    // 2: bottom-right corner, three pixels clipped
    vbegin(1, 639, 479);
    pix(0, 1, 307199); pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    vend();
    // 3: erase the clipped square, draw at origin
    vbegin(1, 0, 0);
    pix(1, 1, 307199); pix(1, 0, 0); pix(1, 0, 0); pix(1, 0, 0);
    pix(0, 1, 0); pix(0, 1, 1); pix(0, 1, 640); pix(0, 1, 641);
    vend();
    // 4: square touching both edges, fully visible
    vbegin(2, 638, 478);
    pix(0, 1, 306558); pix(0, 1, 306559); pix(0, 1, 307198); pix(0, 1, 307199);
    vend();
    // 5: id0 jumps far away
    vbegin(0, 5, 3);
    pix(1, 1, 64101); pix(1, 1, 64102); pix(1, 1, 64741); pix(1, 1, 64742);
    pix(0, 1, 1925); pix(0, 1, 1926); pix(0, 1, 2565); pix(0, 1, 2566);
    vend();
    // 6: id4 redrawn after a reset aborted its first draw
    vbegin(4, 200, 50);
    pix(0, 1, 32200); pix(0, 1, 32201); pix(0, 1, 32840); pix(0, 1, 32841);
    vend();
    // 7: id0 after reset: valid cleared, so no erase
    vbegin(0, 5, 3);
    pix(0, 1, 1925); pix(0, 1, 1926); pix(0, 1, 2565); pix(0, 1, 2566);
    vend();

    for (int unsigned i = 0; i < 6; i++) run_vec(i);

    // Back-to-back: in_valid held high with a second update queued.
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = 3'd3; bus.in_x = 10'd10; bus.in_y = 9'd10;
    @(negedge clock);
    bus.in_x = 10'd20;
    rdy = 0;
    for (int unsigned c = 1; c <= 24 && rdy == 0; c++) begin
      if (bus.in_ready) begin
        rdy = c;
        chk("b2b_done_with_ready", bus.done, 1);
      end else begin
        @(negedge clock);
      end
    end
    chk("b2b_ready_cycle", rdy, 6);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("b2b_second_accepted", bus.in_ready, 0);
    @(negedge clock);
    chk("b2b_first_we", bus.fb_we, 1);
    chk("b2b_first_addr", bus.fb_addr, TRAIL ? 20'd6420 : 20'd6410);
    chk("b2b_first_data", bus.fb_wdata, TRAIL ? 9'h0FF : 9'h000);
    d = 0;
    for (int unsigned c = 3; c <= 24 && d == 0; c++) begin
      @(negedge clock);
      if (bus.done) d = c;
    end
    chk("b2b_second_done", d, TRAIL ? 6 : 10);

    // Reset in the middle of a draw of id4.
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_id = 3'd4; bus.in_x = 10'd200; bus.in_y = 9'd50;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("rmid_w0_addr", bus.fb_addr, 32200);
    @(negedge clock);
    chk("rmid_w1_addr", bus.fb_addr, 32201);
    reset = 1'b1;
    @(negedge clock);
    chk("rmid_we_off", bus.fb_we, 0);
    chk("rmid_done_off", bus.done, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rmid_ready", bus.in_ready, 1);
    run_vec(6);
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
